// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - coin-operated vending controller with vend and change handshakes
`timescale 1ns/1ps

module vend_ctrl #(
    parameter int PRICE    = 4,
    parameter int VALUE_W  = 2,
    parameter int CREDIT_W = 4,
    parameter int COUNT_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                io_coin_valid,
    input  logic [VALUE_W-1:0]  io_coin_value,
    output logic                io_coin_ready,
    input  logic                io_cancel,
    output logic                io_reject,
    output logic                io_vend_valid,
    input  logic                io_vend_ready,
    output logic                io_change_valid,
    output logic [CREDIT_W-1:0] io_change_value,
    input  logic                io_change_ready,
    output logic [CREDIT_W-1:0] io_credit,
    output logic [COUNT_W-1:0]  io_vend_count
);

    localparam int SUM_W = CREDIT_W + 1;

    // Sum is one bit wider than credit so an overflowing coin is detectable.
    localparam logic [SUM_W-1:0]    MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [SUM_W-1:0]    PRICE_SUM  = SUM_W'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_CR   = CREDIT_W'(PRICE);

    typedef enum logic [1:0] {
        ST_ACCEPT,
        ST_VEND,
        ST_CHANGE
    } state_t;

    state_t              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [COUNT_W-1:0]  count_q;
    logic                reject_q;
    logic                vend_valid_q;
    logic                change_valid_q;

    logic                coin_fire;
    logic                cancel_take;
    logic [SUM_W-1:0]    coin_sum;
    logic [CREDIT_W-1:0] remainder;

    // Coins are only taken while accepting and never while reset is held.
    assign io_coin_ready = (state_q == ST_ACCEPT) & ~reset;
    assign coin_fire     = io_coin_valid & io_coin_ready;
    // Cancel with no credit is a no-op, so a coin in that cycle is processed normally.
    assign cancel_take   = io_cancel & (credit_q != '0);
    assign coin_sum      = {1'b0, credit_q} + SUM_W'(io_coin_value);
    assign remainder     = credit_q - PRICE_CR;

    assign io_reject       = reject_q;
    assign io_vend_valid   = vend_valid_q;
    assign io_change_valid = change_valid_q;
    assign io_change_value = credit_q;
    assign io_credit       = credit_q;
    assign io_vend_count   = count_q;

    // Controller FSM: credit accumulation, vend handshake, change/refund handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_ACCEPT;
            credit_q       <= '0;
            count_q        <= '0;
            reject_q       <= 1'b0;
            vend_valid_q   <= 1'b0;
            change_valid_q <= 1'b0;
        end else begin
            reject_q <= 1'b0;
            case (state_q)
                ST_ACCEPT: begin
                    if (cancel_take) begin
                        // Refund everything; a coin handed over this cycle goes straight back.
                        state_q        <= ST_CHANGE;
                        change_valid_q <= 1'b1;
                        reject_q       <= coin_fire;
                    end else if (coin_fire) begin
                        if (coin_sum <= MAX_CREDIT) begin
                            credit_q <= coin_sum[CREDIT_W-1:0];
                            if (coin_sum >= PRICE_SUM) begin
                                state_q      <= ST_VEND;
                                vend_valid_q <= 1'b1;
                            end
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end
                end
                ST_VEND: begin
                    if (io_vend_ready) begin
                        credit_q     <= remainder;
                        count_q      <= count_q + COUNT_W'(1);
                        vend_valid_q <= 1'b0;
                        if (remainder != '0) begin
                            state_q        <= ST_CHANGE;
                            change_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_ACCEPT;
                        end
                    end
                end
                ST_CHANGE: begin
                    if (io_change_ready) begin
                        credit_q       <= '0;
                        change_valid_q <= 1'b0;
                        state_q        <= ST_ACCEPT;
                    end
                end
                default: begin
                    state_q        <= ST_ACCEPT;
                    vend_valid_q   <= 1'b0;
                    change_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// tb/tb_vend_ctrl.sv - self-checking bench for vend_ctrl
`timescale 1ns/1ps

module tb_vend_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // default-parameter DUT
    logic       coin_valid;
    logic [1:0] coin_value;
    logic       coin_ready;
    logic       cancel;
    logic       reject;
    logic       vend_valid;
    logic       vend_ready;
    logic       change_valid;
    logic [3:0] change_value;
    logic       change_ready;
    logic [3:0] credit;
    logic [7:0] vend_count;

    // PRICE=15 DUT
    logic       p_coin_valid;
    logic [1:0] p_coin_value;
    logic       p_coin_ready;
    logic       p_cancel;
    logic       p_reject;
    logic       p_vend_valid;
    logic       p_vend_ready;
    logic       p_change_valid;
    logic [3:0] p_change_value;
    logic       p_change_ready;
    logic [3:0] p_credit;
    logic [7:0] p_vend_count;

    vend_ctrl u_dut (
        .clk             (clk),
        .reset           (reset),
        .io_coin_valid   (coin_valid),
        .io_coin_value   (coin_value),
        .io_coin_ready   (coin_ready),
        .io_cancel       (cancel),
        .io_reject       (reject),
        .io_vend_valid   (vend_valid),
        .io_vend_ready   (vend_ready),
        .io_change_valid (change_valid),
        .io_change_value (change_value),
        .io_change_ready (change_ready),
        .io_credit       (credit),
        .io_vend_count   (vend_count)
    );

    vend_ctrl #(.PRICE(15)) u_dut15 (
        .clk             (clk),
        .reset           (reset),
        .io_coin_valid   (p_coin_valid),
        .io_coin_value   (p_coin_value),
        .io_coin_ready   (p_coin_ready),
        .io_cancel       (p_cancel),
        .io_reject       (p_reject),
        .io_vend_valid   (p_vend_valid),
        .io_vend_ready   (p_vend_ready),
        .io_change_valid (p_change_valid),
        .io_change_value (p_change_value),
        .io_change_ready (p_change_ready),
        .io_credit       (p_credit),
        .io_vend_count   (p_vend_count)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] exp_count;
    logic [3:0] exp_change_q[$];
    logic [7:0] exp_vend_q[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        step();
        coin_valid = 1'b0;
        coin_value = 2'd0;
    endtask

    task automatic p_coin(input logic [1:0] v);
        p_coin_valid = 1'b1;
        p_coin_value = v;
        step();
        p_coin_valid = 1'b0;
        p_coin_value = 2'd0;
    endtask

    task automatic push_vend();
        exp_vend_q.push_back(exp_count);
        exp_count = exp_count + 8'd1;
    endtask

    // Scoreboard: each handshake the DUT is about to complete is matched against the queues.
    always @(negedge clk) begin
        if (!reset && vend_valid && vend_ready) begin
            if (exp_vend_q.size() == 0) check_eq("sb_vend_unexpected", exp_vend_q.size(), 1);
            else check_eq("sb_vend_count", vend_count, exp_vend_q.pop_front());
        end
        if (!reset && change_valid && change_ready) begin
            if (exp_change_q.size() == 0) check_eq("sb_change_unexpected", exp_change_q.size(), 1);
            else check_eq("sb_change_value", change_value, exp_change_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        coin_valid = 1'b0; coin_value = 2'd0; cancel = 1'b0;
        vend_ready = 1'b0; change_ready = 1'b0;
        p_coin_valid = 1'b0; p_coin_value = 2'd0; p_cancel = 1'b0;
        p_vend_ready = 1'b0; p_change_ready = 1'b0;
        exp_count = 8'd0;
        step();
        step();

        // reset state
        check_eq("rst_credit", credit, 0);
        check_eq("rst_count", vend_count, 0);
        check_eq("rst_vend_valid", vend_valid, 0);
        check_eq("rst_change_valid", change_valid, 0);
        check_eq("rst_reject", reject, 0);
        check_eq("rst_coin_ready", coin_ready, 0);
        check_eq("rst_p15_credit", p_credit, 0);
        reset = 1'b0;
        #1;
        check_eq("coin_ready_after_reset", coin_ready, 1);

        // PRICE=15: overflow reject, then exact price
        p_coin(2'd3); p_coin(2'd3); p_coin(2'd3); p_coin(2'd3); p_coin(2'd2);
        check_eq("p15_credit14", p_credit, 14);
        p_coin(2'd3);
        check_eq("p15_reject", p_reject, 1);
        check_eq("p15_credit_hold", p_credit, 14);
        step();
        check_eq("p15_reject_one_cycle", p_reject, 0);
        p_coin(2'd1);
        check_eq("p15_credit15", p_credit, 15);
        check_eq("p15_vend_valid", p_vend_valid, 1);
        p_vend_ready = 1'b1;
        step();
        p_vend_ready = 1'b0;
        check_eq("p15_credit_after", p_credit, 0);
        check_eq("p15_no_change", p_change_valid, 0);
        check_eq("p15_count", p_vend_count, 1);
        check_eq("p15_coin_ready", p_coin_ready, 1);

        // zero-value coin, then four unit coins
        coin(2'd0);
        check_eq("t1_zero_coin", credit, 0);
        check_eq("t1_zero_no_vend", vend_valid, 0);
        for (int i = 0; i < 4; i++) begin
            coin(2'd1);
            check_eq("t1_credit", credit, i + 1);
            check_eq("t1_vend_valid", vend_valid, (i == 3) ? 1 : 0);
        end
        push_vend();
        vend_ready = 1'b1;
        step();
        vend_ready = 1'b0;
        check_eq("t1_credit_after", credit, 0);
        check_eq("t1_count", vend_count, exp_count);
        check_eq("t1_no_change", change_valid, 0);
        check_eq("t1_coin_ready", coin_ready, 1);

        // 3+3 with backpressure, then change 2
        coin(2'd3);
        check_eq("t2_credit3", credit, 3);
        coin(2'd3);
        check_eq("t2_credit6", credit, 6);
        check_eq("t2_vend_valid", vend_valid, 1);
        for (int i = 0; i < 3; i++) begin
            coin_valid = 1'b1;
            coin_value = 2'd1;
            step();
            check_eq("t2_hold_vend_valid", vend_valid, 1);
            check_eq("t2_hold_coin_ready", coin_ready, 0);
            check_eq("t2_hold_reject", reject, 0);
            check_eq("t2_hold_credit", credit, 6);
        end
        coin_valid = 1'b0;
        coin_value = 2'd0;
        push_vend();
        exp_change_q.push_back(4'd2);
        vend_ready = 1'b1;
        step();
        vend_ready = 1'b0;
        check_eq("t2_change_valid", change_valid, 1);
        check_eq("t2_change_value", change_value, 2);
        check_eq("t2_vend_valid_low", vend_valid, 0);
        check_eq("t2_count", vend_count, exp_count);
        change_ready = 1'b1;
        step();
        change_ready = 1'b0;
        check_eq("t2_change_done", change_valid, 0);
        check_eq("t2_credit_zero", credit, 0);
        check_eq("t2_coin_ready", coin_ready, 1);

        // cancel refund
        coin(2'd2);
        exp_change_q.push_back(4'd2);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check_eq("t3_change_valid", change_valid, 1);
        check_eq("t3_change_value", change_value, 2);
        change_ready = 1'b1;
        step();
        change_ready = 1'b0;
        check_eq("t3_count_unchanged", vend_count, exp_count);
        check_eq("t3_coin_ready", coin_ready, 1);
        check_eq("t3_credit_zero", credit, 0);

        // cancel with simultaneous coin
        coin(2'd3);
        check_eq("t4_credit3", credit, 3);
        exp_change_q.push_back(4'd3);
        cancel = 1'b1;
        coin(2'd1);
        cancel = 1'b0;
        check_eq("t4_change_valid", change_valid, 1);
        check_eq("t4_reject", reject, 1);
        check_eq("t4_change_value", change_value, 3);
        change_ready = 1'b1;
        step();
        change_ready = 1'b0;
        check_eq("t4_reject_low", reject, 0);
        check_eq("t4_change_done", change_valid, 0);
        check_eq("t4_credit_zero", credit, 0);

        // cancel at zero credit is ignored; simultaneous coin is taken
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check_eq("t5_cancel0_change", change_valid, 0);
        check_eq("t5_cancel0_ready", coin_ready, 1);
        check_eq("t5_cancel0_reject", reject, 0);
        cancel = 1'b1;
        coin(2'd1);
        cancel = 1'b0;
        check_eq("t5_cancel0_coin", credit, 1);
        check_eq("t5_cancel0_no_change", change_valid, 0);
        check_eq("t5_cancel0_no_reject", reject, 0);
        coin(2'd3);
        check_eq("t5_vend_valid", vend_valid, 1);
        push_vend();
        vend_ready = 1'b1;
        step();
        vend_ready = 1'b0;
        check_eq("t5_count", vend_count, exp_count);
        check_eq("t5_credit_zero", credit, 0);

        // reset mid-VEND
        coin(2'd2);
        coin(2'd2);
        check_eq("t6_vend_valid", vend_valid, 1);
        reset = 1'b1;
        step();
        check_eq("t6_rst_vend_valid", vend_valid, 0);
        check_eq("t6_rst_credit", credit, 0);
        check_eq("t6_rst_count", vend_count, 0);
        check_eq("t6_rst_reject", reject, 0);
        check_eq("t6_rst_change_valid", change_valid, 0);
        exp_count = 8'd0;
        reset = 1'b0;
        #1;
        check_eq("t6_coin_ready", coin_ready, 1);

        // 256 vends wrap the counter
        for (int i = 0; i < 256; i++) begin
            push_vend();
            coin(2'd3);
            coin(2'd1);
            vend_ready = 1'b1;
            step();
            vend_ready = 1'b0;
        end
        check_eq("t7_count_wrap", vend_count, exp_count);
        check_eq("t7_count_zero", vend_count, 0);
        check_eq("t7_credit_zero", credit, 0);

        step();
        check_eq("sb_vend_drained", exp_vend_q.size(), 0);
        check_eq("sb_change_drained", exp_change_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Parametrised coin-operated vending controller: accumulates credit from multi-value coins, issues a vend request through a valid/ready handshake once credit reaches a configurable price, and returns change or a full refund on cancel through a second valid/ready handshake. It generalises the single-unit, fixed-price vending FSM and sits between the coin-acceptor front end and the dispenser/change-hopper drivers in the vending examples.

## Interface
- PRICE, 4, item price in coin units; legal range 1..2^CREDIT_W-1
- VALUE_W, 2, coin value width; coin values 0..2^VALUE_W-1
- CREDIT_W, 4, credit register width; MAX_CREDIT = 2^CREDIT_W-1
- COUNT_W, 8, vend counter width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- io_coin_valid  in  1  coin presented this cycle
- io_coin_value  in  VALUE_W  value of presented coin
- io_coin_ready  out  1  controller can accept a coin
- io_cancel  in  1  refund request, single-cycle sample
- io_reject  out  1  one-cycle pulse: accepted-handshake coin was returned unused
- io_vend_valid  out  1  dispense request
- io_vend_ready  in  1  dispenser takes the request
- io_change_valid  out  1  change/refund request
- io_change_value  out  CREDIT_W  amount to return, stable while io_change_valid
- io_change_ready  in  1  change hopper takes the request
- io_credit  out  CREDIT_W  current credit
- io_vend_count  out  COUNT_W  completed vends, wraps modulo 2^COUNT_W

## Operation
- States: ACCEPT, VEND, CHANGE. Reset -> ACCEPT, credit 0, vend count 0, io_reject 0.
- io_coin_ready = (state==ACCEPT) & !reset. Coin handshake = io_coin_valid & io_coin_ready.
- ACCEPT, handshake, no cancel: if credit+value <= MAX_CREDIT then credit += value (sum computed at CREDIT_W+1 bits); else credit unchanged, io_reject=1 next cycle.
- ACCEPT -> VEND when the updated credit >= PRICE; the state register and the credit update take effect on the same edge.
- ACCEPT, io_cancel=1, credit>0: -> CHANGE with io_change_value=credit. Coin presented the same cycle is not added, and io_reject pulses. Cancel with credit 0: ignored; a simultaneous coin is handled normally.
- VEND: io_vend_valid=1. On io_vend_ready: credit -= PRICE, io_vend_count += 1; -> CHANGE if the remainder is >0, else -> ACCEPT. io_cancel is ignored.
- CHANGE: io_change_valid=1, io_change_value=credit. On io_change_ready: credit=0 -> ACCEPT. io_cancel is ignored.
- io_vend_ready and io_change_ready have no effect while the matching valid is low.
- Coin value 0 handshakes normally and leaves credit unchanged.
- No coins are accepted in VEND or CHANGE. io_coin_ready=0, so there is no handshake and no reject.

## Timing
- All outputs except io_coin_ready are registered-state decodes. io_coin_ready is combinational from state and reset.
- Coin -> io_credit update: 1 cycle. Coin reaching price -> io_vend_valid high: 1 cycle.
- io_vend_valid and io_change_valid stay high until their ready is sampled high. Minimum assertion is 1 cycle.
- Vend handshake -> io_change_valid or io_coin_ready high: 1 cycle. Change handshake -> io_coin_ready high: 1 cycle.
- io_reject is high exactly one cycle, the cycle after the rejected handshake.
- Reset in any state, including mid-VEND or mid-CHANGE: next cycle all valids 0, io_credit 0, io_vend_count 0, io_reject 0. A pending handshake is discarded.

## Test plan
- Defaults. Four value-1 coins on consecutive cycles -> io_credit 1,2,3,4. io_vend_valid rises the cycle after the 4th coin; with ready=1: io_credit 0, io_vend_count 1, no io_change_valid, io_coin_ready back high next cycle.
- Defaults. Coins 3,3 -> credit 6, VEND. Hold io_vend_ready low 3 cycles while driving coins: io_vend_valid held, io_coin_ready 0, no reject, credit stays 6. Then ready=1 -> io_change_valid with io_change_value 2; io_change_ready=1 -> credit 0, ACCEPT.
- Defaults. Coin 2, then io_cancel -> io_change_value 2; after the change handshake io_vend_count stays 0.
- Defaults. With credit 3, io_cancel and a value-1 coin in the same cycle -> refund 3 and io_reject pulse. io_cancel at credit 0 -> no state change.
- PRICE=15. Coins totalling 14, then a value-3 coin -> io_reject pulse, credit stays 14. Then value-1 coin -> credit 15, vend, no change.
- Assert reset during VEND with io_vend_ready low -> next cycle io_vend_valid 0, io_credit 0, io_vend_count 0, io_coin_ready 1 after reset falls. Also run 256 vends with COUNT_W=8 -> count wraps to 0.
